// File: rtl/led_mode_pkg.sv
// Shared encodings for the gesture-driven LED mode controller: FSM states,
// gesture codes and LED effect codes.
package led_mode_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReady,
        StSelect,
        StSuccess,
        StCancel
    } state_e;

    localparam logic [3:0] GestUp    = 4'd1;
    localparam logic [3:0] GestDown  = 4'd2;
    localparam logic [3:0] GestLeft  = 4'd3;
    localparam logic [3:0] GestRight = 4'd4;
    localparam logic [3:0] GestFwd   = 4'd5;
    localparam logic [3:0] GestBack  = 4'd6;
    localparam logic [3:0] GestWave  = 4'd9;

    localparam logic [3:0] ValOff    = 4'd0;
    localparam logic [3:0] ValAll    = 4'd1;
    localparam logic [3:0] ValSingle = 4'd2;
    localparam logic [3:0] ValRun    = 4'd6;
    localparam logic [3:0] ValFlash  = 4'd7;

    function automatic logic [3:0] value_of(state_e st, logic [1:0] item);
        case (st)
            StReady:   return ValAll;
            StSelect:  return ValSingle + {2'b00, item};
            StSuccess: return ValRun;
            StCancel:  return ValFlash;
            default:   return ValOff;
        endcase
    endfunction

endpackage

// File: rtl/beep_pulse_gen.sv
// Retriggerable buzzer pulse: beep_en is high for exactly T_BEEP cycles
// starting at the edge that samples trigger; a new trigger restarts the count.
module beep_pulse_gen #(
    parameter int unsigned T_BEEP = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic beep_en
);

    localparam logic [31:0] BeepLast = (T_BEEP != 0) ? 32'(T_BEEP - 1) : 32'd0;

    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            beep_en <= 1'b0;
        end else if (trigger) begin
            cnt     <= BeepLast;
            beep_en <= (T_BEEP != 0);
        end else if (cnt != '0) begin
            cnt <= cnt - 32'd1;
        end else begin
            beep_en <= 1'b0;
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// Gesture-driven LED mode controller: walks IDLE/READY/SELECT/SUCCESS/CANCEL,
// drives the LED effect code and triggers a buzzer pulse on every accepted gesture.
module led_mode_ctrl
    import led_mode_pkg::*;
#(
    parameter int unsigned T_BEEP    = 5_000_000,
    parameter int unsigned T_SUCCESS = 100_000_000,
    parameter int unsigned T_CANCEL  = 50_000_000,
    parameter int unsigned T_IDLE_TO = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gest_vld,
    input  logic [3:0] gest_code,
    output logic       gest_ack,
    output logic [3:0] value,
    output logic [1:0] item_sel,
    output logic       beep_en
);

    // Timer is loaded with hold-1 on entry and the state exits when it reads 0.
    localparam logic [31:0] HoldSuccess = 32'(T_SUCCESS - 1);
    localparam logic [31:0] HoldCancel  = 32'(T_CANCEL - 1);
    localparam logic [31:0] HoldIdleTo  = 32'(T_IDLE_TO - 1);

    state_e      state, state_d;
    logic [1:0]  item_sel_d;
    logic [31:0] timer, timer_d;
    logic        accept;

    always_comb begin
        accept     = 1'b0;
        state_d    = state;
        item_sel_d = item_sel;
        timer_d    = timer;

        if (gest_vld) begin
            case (state)
                StIdle: begin
                    if (gest_code == GestWave) begin
                        accept  = 1'b1;
                        state_d = StReady;
                    end
                end
                StReady, StSelect: begin
                    if (gest_code >= GestUp && gest_code <= GestRight) begin
                        accept     = 1'b1;
                        state_d    = StSelect;
                        item_sel_d = 2'(gest_code - GestUp);
                    end else if (gest_code == GestFwd && state == StSelect) begin
                        accept  = 1'b1;
                        state_d = StSuccess;
                    end else if (gest_code == GestBack) begin
                        accept  = 1'b1;
                        state_d = StCancel;
                    end
                end
                default: ;
            endcase
        end

        // An accepted gesture wins over a timeout expiring in the same cycle.
        if (accept) begin
            case (state_d)
                StSuccess: timer_d = HoldSuccess;
                StCancel:  timer_d = HoldCancel;
                default:   timer_d = HoldIdleTo;
            endcase
        end else if (state != StIdle) begin
            if (timer == '0) begin
                state_d    = StIdle;
                item_sel_d = 2'd0;
            end else begin
                timer_d = timer - 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            timer    <= '0;
            item_sel <= 2'd0;
            value    <= ValOff;
            gest_ack <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            item_sel <= item_sel_d;
            value    <= value_of(state_d, item_sel_d);
            gest_ack <= accept;
        end
    end

    beep_pulse_gen #(
        .T_BEEP(T_BEEP)
    ) u_beep (
        .clk    (clk),
        .rst_n  (rst_n),
        .trigger(accept),
        .beep_en(beep_en)
    );

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench: deadline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized gestures and resets.
module tb_led_mode_ctrl;

    localparam int TB = 4;
    localparam int TS = 20;
    localparam int TC = 10;
    localparam int TI = 50;

    localparam int M_IDLE = 0, M_READY = 1, M_SELECT = 2, M_SUCCESS = 3, M_CANCEL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gest_vld = 1'b0;
    logic [3:0] gest_code = 4'd0;
    logic       gest_ack;
    logic [3:0] value;
    logic [1:0] item_sel;
    logic       beep_en;

    int total = 0;
    int bad = 0;

    led_mode_ctrl #(
        .T_BEEP   (TB),
        .T_SUCCESS(TS),
        .T_CANCEL (TC),
        .T_IDLE_TO(TI)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gest_vld (gest_vld),
        .gest_code(gest_code),
        .gest_ack (gest_ack),
        .value    (value),
        .item_sel (item_sel),
        .beep_en  (beep_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: absolute cycle deadlines instead of countdowns.
    longint cyc = 0;
    longint m_end = 0;
    longint m_beep_end = 0;
    int     m_st = M_IDLE;
    int     m_item = 0;
    bit     m_ack = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_end = 0; m_beep_end = 0;
            m_st = M_IDLE; m_item = 0; m_ack = 0;
        end else begin
            cyc++;
            m_ack = 0;
            if (gest_vld) begin
                if (m_st == M_IDLE) begin
                    if (gest_code == 4'd9) begin
                        m_ack = 1; m_st = M_READY; m_end = cyc + TI;
                    end
                end else if (m_st == M_READY || m_st == M_SELECT) begin
                    if (gest_code >= 4'd1 && gest_code <= 4'd4) begin
                        m_ack = 1; m_st = M_SELECT; m_item = int'(gest_code) - 1;
                        m_end = cyc + TI;
                    end else if (gest_code == 4'd5 && m_st == M_SELECT) begin
                        m_ack = 1; m_st = M_SUCCESS; m_end = cyc + TS;
                    end else if (gest_code == 4'd6) begin
                        m_ack = 1; m_st = M_CANCEL; m_end = cyc + TC;
                    end
                end
            end
            if (m_ack) m_beep_end = cyc + TB;
            else if (m_st != M_IDLE && cyc == m_end) begin
                m_st = M_IDLE; m_item = 0;
            end
        end
    end

    function automatic int exp_value();
        case (m_st)
            M_READY:   return 1;
            M_SELECT:  return 2 + m_item;
            M_SUCCESS: return 6;
            M_CANCEL:  return 7;
            default:   return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        check("model value", 32'(value), 32'(exp_value()));
        check("model item_sel", 32'(item_sel), 32'(m_item));
        check("model gest_ack", 32'(gest_ack), 32'(m_ack));
        check("model beep_en", 32'(beep_en), 32'(cyc < m_beep_end));
    end

    task automatic gesture(input logic [3:0] c);
        @(negedge clk);
        gest_vld  = 1'b1;
        gest_code = c;
        @(negedge clk);
        gest_vld  = 1'b0;
    endtask

    int  nv, nb, rises;
    bit  prev_b;
    int  dens;

    initial begin
        #12;
        check("reset value", 32'(value), 32'd0);
        check("reset item_sel", 32'(item_sel), 32'd0);
        check("reset gest_ack", 32'(gest_ack), 32'd0);
        check("reset beep_en", 32'(beep_en), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // wave, up, forward -> 1, 2, then 6 for 20 cycles
        gesture(4'd9);
        check("wave value", 32'(value), 32'd1);
        check("wave ack", 32'(gest_ack), 32'd1);
        check("wave beep", 32'(beep_en), 32'd1);
        gesture(4'd1);
        check("up value", 32'(value), 32'd2);
        check("up item", 32'(item_sel), 32'd0);
        check("up ack", 32'(gest_ack), 32'd1);
        gesture(4'd5);
        check("fwd ack", 32'(gest_ack), 32'd1);
        nv = (value == 4'd6) ? 1 : 0;
        nb = beep_en ? 1 : 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (value == 4'd6) nv++;
            if (beep_en) nb++;
        end
        check("success hold cycles", 32'(nv), 32'd20);
        check("success beep cycles", 32'(nb), 32'd4);
        check("after success value", 32'(value), 32'd0);

        // wave, right, backward -> 1, 5, then 7 for 10 cycles
        gesture(4'd9);
        gesture(4'd4);
        check("right value", 32'(value), 32'd5);
        check("right item", 32'(item_sel), 32'd3);
        gesture(4'd6);
        nv = (value == 4'd7) ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (value == 4'd7) nv++;
        end
        check("cancel hold cycles", 32'(nv), 32'd10);
        check("after cancel value", 32'(value), 32'd0);
        check("after cancel item", 32'(item_sel), 32'd0);

        // inactivity timeout, then a gesture in the last READY cycle
        gesture(4'd9);
        nv = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (value != 4'd1) break;
            nv++;
        end
        check("ready timeout cycles", 32'(nv), 32'd50);
        check("timeout value", 32'(value), 32'd0);
        gesture(4'd9);
        repeat (48) @(negedge clk);
        gesture(4'd1);
        check("late gesture keeps select", 32'(value), 32'd2);
        repeat (60) @(negedge clk);

        // forward ignored in IDLE, READY, SUCCESS
        gesture(4'd5);
        check("fwd idle ack", 32'(gest_ack), 32'd0);
        check("fwd idle beep", 32'(beep_en), 32'd0);
        check("fwd idle value", 32'(value), 32'd0);
        gesture(4'd9);
        repeat (5) @(negedge clk);
        gesture(4'd5);
        check("fwd ready ack", 32'(gest_ack), 32'd0);
        check("fwd ready beep", 32'(beep_en), 32'd0);
        check("fwd ready value", 32'(value), 32'd1);
        gesture(4'd2);
        gesture(4'd5);
        repeat (5) @(negedge clk);
        gesture(4'd5);
        check("fwd success ack", 32'(gest_ack), 32'd0);
        check("fwd success beep", 32'(beep_en), 32'd0);
        check("fwd success value", 32'(value), 32'd6);
        repeat (30) @(negedge clk);

        // two accepts two cycles apart -> one contiguous 6-cycle beep
        gesture(4'd9);
        nb = 0; rises = 0; prev_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (beep_en) nb++;
            if (beep_en && !prev_b) rises++;
            prev_b = beep_en;
            gest_vld  = (i == 1);
            gest_code = 4'd1;
            @(negedge clk);
        end
        check("overlap beep cycles", 32'(nb), 32'd6);
        check("overlap beep contiguous", 32'(rises), 32'd1);
        repeat (60) @(negedge clk);

        // reset mid-SUCCESS and mid-beep
        gesture(4'd9);
        gesture(4'd1);
        gesture(4'd5);
        repeat (8) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async reset value", 32'(value), 32'd0);
        check("async reset item", 32'(item_sel), 32'd0);
        check("async reset beep", 32'(beep_en), 32'd0);
        #1 rst_n = 1'b1;
        gesture(4'd9);
        check("pre-reset beep", 32'(beep_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid-beep reset beep", 32'(beep_en), 32'd0);
        check("mid-beep reset value", 32'(value), 32'd0);
        #1 rst_n = 1'b1;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (beep_en || value != 4'd0) nb++;
        end
        check("no residual after reset", 32'(nb), 32'd0);

        // randomized gestures with occasional resets and quiet stretches
        for (int blk = 0; blk < 30; blk++) begin
            dens = $urandom_range(0, 3);
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                gest_vld = (dens != 0) && ($urandom_range(0, dens * 3) == 0);
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 6))
                        0: gest_code = 4'd1;
                        1: gest_code = 4'd2;
                        2: gest_code = 4'd3;
                        3: gest_code = 4'd4;
                        4: gest_code = 4'd5;
                        5: gest_code = 4'd6;
                        default: gest_code = 4'd9;
                    endcase
                end else begin
                    gest_code = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 499) == 0) begin
                    #1 rst_n = 1'b0;
                    #2 rst_n = 1'b1;
                end
            end
        end
        @(negedge clk);
        gest_vld = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 SHALL have parameter T_BEEP, default 5_000_000, beep pulse length in clk cycles (0.1 s at 50 MHz).
REQ-002 SHALL have parameter T_SUCCESS, default 100_000_000, running-light hold time in cycles (2 s).
REQ-003 SHALL have parameter T_CANCEL, default 50_000_000, flash hold time in cycles (1 s).
REQ-004 SHALL have parameter T_IDLE_TO, default 500_000_000, inactivity timeout in cycles (10 s).
REQ-005 SHALL have port clk  input  1  system clock, single clock domain.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port gest_vld  input  1  one-cycle strobe, gesture code valid.
REQ-008 SHALL have port gest_code  input  4  gesture code: 1 up, 2 down, 3 left, 4 right, 5 forward, 6 backward, 9 wave; others unused.
REQ-009 SHALL have port gest_ack  output  1  one-cycle pulse, gesture accepted.
REQ-010 SHALL have port value  output  4  LED effect code to the LED/beep driver: 0 off, 1 all on, 2..5 single LED, 6 running, 7 flash.
REQ-011 SHALL have port item_sel  output  2  currently selected item index.
REQ-012 SHALL have port beep_en  output  1  buzzer enable.

Function
REQ-013 SHALL implement FSM states IDLE, READY, SELECT, SUCCESS, CANCEL, all registered.
REQ-014 SHALL drive value from state: IDLE 0, READY 1, SELECT 2+item_sel, SUCCESS 6, CANCEL 7.
REQ-015 SHALL make state, value, item_sel, gest_ack and beep_en change on the clk edge after the gest_vld cycle (1-cycle latency).
REQ-016 SHALL accept in IDLE only code 9: IDLE->READY.
REQ-017 SHALL accept in READY or SELECT codes 1..4: go to SELECT, item_sel = code-1; re-selection in SELECT overwrites item_sel.
REQ-018 SHALL accept code 5 only in SELECT: ->SUCCESS; code 5 in READY is ignored.
REQ-019 SHALL accept code 6 in READY or SELECT: ->CANCEL.
REQ-020 SHALL ignore every gesture in SUCCESS or CANCEL, and every unlisted code in any state: no ack, no beep, no state change.
REQ-021 SHALL pulse gest_ack high for exactly one cycle per accepted gesture.
REQ-022 SHALL hold SUCCESS for exactly T_SUCCESS cycles and CANCEL for exactly T_CANCEL cycles, then enter IDLE.
REQ-023 SHALL return READY/SELECT to IDLE after T_IDLE_TO cycles without an accepted gesture; each accepted gesture restarts this timer.
REQ-024 SHALL assert beep_en for exactly T_BEEP cycles after each accepted gesture; a new accept during an active beep restarts the full T_BEEP count.
REQ-025 SHALL clear item_sel to 0 on every entry to IDLE.
REQ-026 SHALL use 32-bit unsigned counters; the state timer and beep timer SHALL be independent.
REQ-027 SHALL give precedence to an accepted gesture over a timeout that expires in the same cycle.

Reset
REQ-028 SHALL on rst_n low, immediately and asynchronously: state IDLE, value 0, item_sel 0, gest_ack 0, beep_en 0, all counters 0.
REQ-029 SHALL abort any hold, timeout or beep in progress when reset asserts mid-operation, with no residual pulse after release.

Structure
REQ-030 SHALL place the state encoding, gesture code constants and value codes in shared package led_mode_pkg.
REQ-031 SHALL implement the beep timer as sub-module beep_pulse_gen (trigger in, beep_en out, parameter T_BEEP).

Verification (T_BEEP=4, T_SUCCESS=20, T_CANCEL=10, T_IDLE_TO=50)
REQ-032 SHALL cover: wave, then up, then forward -> value 1, then 2, then 6 for exactly 20 cycles, then 0; three gest_ack pulses; beep_en high 4 cycles after each.
REQ-033 SHALL cover: wave, right, backward -> value 1, 5, then 7 for exactly 10 cycles, then 0; item_sel 3, then 0 in IDLE.
REQ-034 SHALL cover: wave, then no gesture -> value returns 0 exactly 50 cycles after the READY entry; a gesture at cycle 49 keeps READY/SELECT.
REQ-035 SHALL cover: forward in IDLE, READY or SUCCESS -> no gest_ack, beep_en stays 0, value unchanged.
REQ-036 SHALL cover: two accepted gestures 2 cycles apart -> beep_en continuously high for 6 cycles total.
REQ-037 SHALL cover: rst_n low mid-SUCCESS (cycle 8) -> value 0 and beep_en 0 without waiting for a clk edge; IDLE after release.
